gesture_match_engine: RTL and testbench
=======================================

// Module: gesture_match_engine
// PURPOSE
// Parametrised template store/match engine for the gesture recognizer. Holds one resampled test
// vector of N_PTS signed (x,y) points, and either enrolls it into a template slot in SRAM or scans
// all enrolled slots. A scan computes a dot-product score per slot and reports the best match or a
// reject. Sits between the resampler (vector write port) and the SRAM controller (req/gnt/rvalid port).
// PARAMETERS
// N_PTS        16  feature points per vector (power of 2, >=2)
// COORD_W      8   signed coordinate width
// N_TMPL       26  template slots
// SLOT_LOG2    10  address stride per slot = 2**SLOT_LOG2 words (>= log2(N_PTS))
// ADDR_W       20  SRAM word address width
// PORTS
// i_clk        in   1                    clock, all logic on rising edge
// i_rst        in   1                    asynchronous, active-high reset
// i_vec_valid  in   1                    write one test-vector point (ignored while o_busy)
// i_vec_idx    in   log2(N_PTS)          point index
// i_vec_x      in   COORD_W              signed x
// i_vec_y      in   COORD_W              signed y
// i_start      in   1                    1-cycle pulse; launches op selected by i_mode (ignored while o_busy)
// i_mode       in   1                    0 = scan/recognize, 1 = enroll into i_slot
// i_slot       in   TIDX_W=clog2(N_TMPL) enroll slot; values >= N_TMPL -> op completes, no writes
// i_clear      in   1                    clear all slot-valid bits (ignored while o_busy)
// i_threshold  in   SCORE_W              signed reject threshold
// o_mem_req    out  1                    memory request, held until i_mem_gnt
// o_mem_we     out  1                    1 = write, 0 = read; stable while o_mem_req
// o_mem_addr   out  ADDR_W               slot*2**SLOT_LOG2 + point
// o_mem_wdata  out  2*COORD_W            {x,y}
// i_mem_gnt    in   1                    request accepted this cycle
// i_mem_rvalid in   1                    read data valid (>=1 cycle after gnt)
// i_mem_rdata  in   2*COORD_W            {x,y} read data
// o_busy       out  1                    operation in progress
// o_done       out  1                    1-cycle pulse at end of every op
// o_match_idx  out  TIDX_W               best slot of last scan
// o_match_score out SCORE_W              signed best score; SCORE_W = 2*COORD_W+1+log2(N_PTS)
// o_reject     out  1                    last scan had no valid slot or best score < i_threshold
// o_tmpl_valid out  N_TMPL               slot-enrolled bitmap
// BEHAVIOUR
// - Reset: all outputs 0, test vector 0, bitmap 0, FSM IDLE. Reset mid-op aborts; no further req.
// - FSM: IDLE -> ENROLL (mode 1) | SCAN_SEL (mode 0). ENROLL -> DONE. SCAN_SEL -> FETCH | DONE.
//   FETCH -> WAIT on gnt; WAIT -> FETCH (more pts) | SCAN_SEL (slot end, on rvalid). DONE -> IDLE.
// - One outstanding transaction max; o_mem_req/we/addr/wdata only change the cycle after gnt.
// - ENROLL: N_PTS writes, point 0..N_PTS-1; bitmap[slot] set in cycle after final gnt; then DONE.
// - SCAN_SEL: walks slot 0..N_TMPL-1, one cycle per invalid slot skipped (no memory traffic);
//   valid slot: clear accumulator, N_PTS reads in point order.
// - Accumulate on rvalid: acc += x_t*x_l + y_t*y_l, signed, full SCORE_W, no saturation.
// - Slot end: if no best yet or acc > best (strict) -> best=acc, idx=slot; ties keep lower slot.
// - DONE (1 cycle): o_done=1, o_busy=0 next cycle. Scan updates o_match_idx/score/reject there;
//   no valid slot -> idx=0, score=0, reject=1. Enroll leaves match outputs unchanged.
// - o_busy high from cycle after accepted i_start through DONE cycle inclusive.
// - i_rvalid outside WAIT and i_gnt without req are ignored.
// - i_start with i_clear same cycle: clear applied first, then op starts.
// - i_vec_valid same cycle as i_start: point written, op uses updated vector.
// - i_threshold sampled in DONE cycle.
// TESTING (N_PTS=4, N_TMPL=4, COORD_W=8, SLOT_LOG2=10; memory model gnt=1 cycle, rvalid +2)
// - Enroll vec (1,0)x4 to slot 2 -> writes addr 2048..2051 wdata 16'h0100, o_tmpl_valid=4'b0100, one o_done.
// - Scan vec (1,0)x4, slots 0:(2,0)x4,1:(3,0)x4 enrolled, thr=0 -> idx=1, score=12, reject=0.
// - Slots 0,3 both score 8 -> idx=0 (tie keeps lower); thr=9 -> reject=1, score=8.
// - i_clear then scan -> zero mem requests, o_done 5 cycles after start, reject=1, score=0.
// - Negative coords: test (-2,3), lib (4,-1) all points -> score 4*(-11) = -44, sign correct.
// - Assert i_rst during WAIT of slot 1 -> o_mem_req=0, o_busy=0, bitmap=0; new scan after release is clean.

Source files
------------

// File: rtl/gesture_match_engine.sv
// Template store / match engine: enrolls the held test vector into an SRAM slot, or scans every
// enrolled slot with a dot-product score and reports the best slot or a reject.
module gesture_match_engine #(
  parameter int N_PTS     = 16,
  parameter int COORD_W   = 8,
  parameter int N_TMPL    = 26,
  parameter int SLOT_LOG2 = 10,
  parameter int ADDR_W    = 20,
  parameter int PIDX_W    = $clog2(N_PTS),
  parameter int TIDX_W    = $clog2(N_TMPL),
  parameter int SCORE_W   = 2*COORD_W + 1 + PIDX_W
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_vec_valid,
  input  logic [PIDX_W-1:0]         i_vec_idx,
  input  logic [COORD_W-1:0]        i_vec_x,
  input  logic [COORD_W-1:0]        i_vec_y,
  input  logic                      i_start,
  input  logic                      i_mode,
  input  logic [TIDX_W-1:0]         i_slot,
  input  logic                      i_clear,
  input  logic signed [SCORE_W-1:0] i_threshold,
  output logic                      o_mem_req,
  output logic                      o_mem_we,
  output logic [ADDR_W-1:0]         o_mem_addr,
  output logic [2*COORD_W-1:0]      o_mem_wdata,
  input  logic                      i_mem_gnt,
  input  logic                      i_mem_rvalid,
  input  logic [2*COORD_W-1:0]      i_mem_rdata,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [TIDX_W-1:0]         o_match_idx,
  output logic signed [SCORE_W-1:0] o_match_score,
  output logic                      o_reject,
  output logic [N_TMPL-1:0]         o_tmpl_valid
);
  // One extra bit so the slot walker can step past the last slot.
  localparam int SW = TIDX_W + 1;

  typedef enum logic [2:0] {S_IDLE, S_ENROLL, S_SCAN_SEL, S_FETCH, S_WAIT, S_DONE} state_t;

  state_t                     state_q, state_d;
  logic [SW-1:0]              slot_q;
  logic [PIDX_W-1:0]          pt_q;
  logic                       mode_q, found_q, reject_q;
  logic signed [SCORE_W-1:0]  acc_q, best_q, score_q;
  logic [TIDX_W-1:0]          best_idx_q, match_idx_q;
  logic [N_TMPL-1:0]          tmpl_valid_q, slot_hit;
  logic signed [COORD_W-1:0]  vx_q [N_PTS];
  logic signed [COORD_W-1:0]  vy_q [N_PTS];

  logic idle, pt_last, slot_ok, slot_last, slot_valid, enroll_fin;
  logic signed [COORD_W-1:0]   lx, ly;
  logic signed [2*COORD_W-1:0] px, py;
  logic signed [SCORE_W-1:0]   acc_sum;

  assign idle       = (state_q == S_IDLE);
  assign pt_last    = (pt_q == PIDX_W'(N_PTS-1));
  assign slot_ok    = (slot_q < SW'(N_TMPL));
  assign slot_last  = (slot_q == SW'(N_TMPL-1));
  assign slot_valid = |(slot_hit & tmpl_valid_q);
  assign enroll_fin = (state_q == S_ENROLL) && slot_ok && i_mem_gnt && pt_last;

  genvar gi;
  generate
    for (gi = 0; gi < N_TMPL; gi++) begin : g_hit
      assign slot_hit[gi] = (slot_q == SW'(gi));
    end
  endgenerate

  // Library point arrives as {x,y}; products are sign-extended into the full score width.
  assign lx      = i_mem_rdata[2*COORD_W-1:COORD_W];
  assign ly      = i_mem_rdata[COORD_W-1:0];
  assign px      = vx_q[pt_q] * lx;
  assign py      = vy_q[pt_q] * ly;
  assign acc_sum = acc_q + {{(SCORE_W-2*COORD_W){px[2*COORD_W-1]}}, px}
                         + {{(SCORE_W-2*COORD_W){py[2*COORD_W-1]}}, py};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:     if (i_start) state_d = i_mode ? S_ENROLL : S_SCAN_SEL;
      S_ENROLL:   if (!slot_ok || (i_mem_gnt && pt_last)) state_d = S_DONE;
      S_SCAN_SEL: if (!slot_ok)       state_d = S_DONE;
                  else if (slot_valid) state_d = S_FETCH;
                  else if (slot_last)  state_d = S_DONE;
      S_FETCH:    if (i_mem_gnt) state_d = S_WAIT;
      S_WAIT:     if (i_mem_rvalid) state_d = pt_last ? S_SCAN_SEL : S_FETCH;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_mem_req   = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if ((state_q == S_ENROLL && slot_ok) || state_q == S_FETCH) begin
      o_mem_req  = 1'b1;
      o_mem_we   = (state_q == S_ENROLL);
      o_mem_addr = (ADDR_W'(slot_q) << SLOT_LOG2) | ADDR_W'(pt_q);
      if (state_q == S_ENROLL) o_mem_wdata = {vx_q[pt_q], vy_q[pt_q]};
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int p = 0; p < N_PTS; p++) begin
        vx_q[p] <= '0;
        vy_q[p] <= '0;
      end
    end else if (idle && i_vec_valid) begin
      for (int p = 0; p < N_PTS; p++) begin
        if (i_vec_idx == PIDX_W'(p)) begin
          vx_q[p] <= i_vec_x;
          vy_q[p] <= i_vec_y;
        end
      end
    end
  end

  // Clear in IDLE and the enroll set can never coincide, so the order here is immaterial.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                 tmpl_valid_q <= '0;
    else if (idle && i_clear)  tmpl_valid_q <= '0;
    else if (enroll_fin)       tmpl_valid_q <= tmpl_valid_q | slot_hit;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      slot_q <= '0; pt_q <= '0; mode_q <= 1'b0; found_q <= 1'b0;
      acc_q <= '0; best_q <= '0; best_idx_q <= '0;
      match_idx_q <= '0; score_q <= '0; reject_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: if (i_start) begin
          mode_q  <= i_mode;
          slot_q  <= i_mode ? SW'(i_slot) : '0;
          pt_q    <= '0;
          found_q <= 1'b0;
        end
        S_ENROLL: if (slot_ok && i_mem_gnt) pt_q <= pt_q + 1'b1;
        S_SCAN_SEL: if (slot_ok && slot_valid) begin
          acc_q <= '0;
          pt_q  <= '0;
        end else begin
          slot_q <= slot_q + 1'b1;
        end
        S_WAIT: if (i_mem_rvalid) begin
          acc_q <= acc_sum;
          pt_q  <= pt_q + 1'b1;
          if (pt_last) begin
            slot_q <= slot_q + 1'b1;
            // Strict compare: ties keep the earlier (lower) slot.
            if (!found_q || acc_sum > best_q) begin
              best_q     <= acc_sum;
              best_idx_q <= slot_q[TIDX_W-1:0];
              found_q    <= 1'b1;
            end
          end
        end
        S_DONE: if (!mode_q) begin
          match_idx_q <= found_q ? best_idx_q : '0;
          score_q     <= found_q ? best_q : '0;
          reject_q    <= !found_q || (best_q < i_threshold);
        end
        default: ;
      endcase
    end
  end

  assign o_busy        = !idle;
  assign o_done        = (state_q == S_DONE);
  assign o_match_idx   = match_idx_q;
  assign o_match_score = score_q;
  assign o_reject      = reject_q;
  assign o_tmpl_valid  = tmpl_valid_q;
endmodule

// File: tb/tb_gesture_match_engine.sv
// Scoreboarded bench for gesture_match_engine: directed cases then randomized enroll/scan traffic
// against a plain-arithmetic reference model and a randomized-latency SRAM model.
module tb_gesture_match_engine;
  localparam int N_PTS = 4, COORD_W = 8, N_TMPL = 4, SLOT_LOG2 = 10, ADDR_W = 20;
  localparam int PIDX_W = 2, TIDX_W = 2, SCORE_W = 2*COORD_W + 1 + PIDX_W;

  logic clk = 1'b0, rst = 1'b1;
  logic vec_valid = 0, start = 0, mode = 0, clear = 0;
  logic [PIDX_W-1:0] vec_idx = '0;
  logic [COORD_W-1:0] vec_x = '0, vec_y = '0;
  logic [TIDX_W-1:0] slot = '0;
  logic [SCORE_W-1:0] thr = '0;
  logic mem_req, mem_we, mem_gnt, mem_rvalid, busy, done, reject;
  logic [ADDR_W-1:0] mem_addr;
  logic [2*COORD_W-1:0] mem_wdata, mem_rdata;
  logic [TIDX_W-1:0] match_idx;
  logic [SCORE_W-1:0] match_score;
  logic [N_TMPL-1:0] tmpl_valid;

  gesture_match_engine #(.N_PTS(N_PTS), .COORD_W(COORD_W), .N_TMPL(N_TMPL),
                         .SLOT_LOG2(SLOT_LOG2), .ADDR_W(ADDR_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_vec_valid(vec_valid), .i_vec_idx(vec_idx),
    .i_vec_x(vec_x), .i_vec_y(vec_y), .i_start(start), .i_mode(mode), .i_slot(slot),
    .i_clear(clear), .i_threshold(thr), .o_mem_req(mem_req), .o_mem_we(mem_we),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .i_mem_gnt(mem_gnt),
    .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata), .o_busy(busy), .o_done(done),
    .o_match_idx(match_idx), .o_match_score(match_score), .o_reject(reject),
    .o_tmpl_valid(tmpl_valid));

  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference model state
  int ref_vx [N_PTS], ref_vy [N_PTS];
  int ref_lx [N_TMPL][N_PTS], ref_ly [N_TMPL][N_PTS];
  bit ref_valid [N_TMPL];
  int last_idx = 0, last_score = 0;
  bit last_rej = 0;

  typedef struct { int idx; int score; bit rej; logic [N_TMPL-1:0] tv; } exp_t;
  exp_t exp_q [$];
  exp_t cur;
  int exp_wr_addr [$], exp_wr_data [$], exp_rd [$];

  task automatic ref_reset();
    for (int p = 0; p < N_PTS; p++) begin ref_vx[p] = 0; ref_vy[p] = 0; end
    for (int s = 0; s < N_TMPL; s++) ref_valid[s] = 0;
    last_idx = 0; last_score = 0; last_rej = 0;
    exp_q.delete(); exp_wr_addr.delete(); exp_wr_data.delete(); exp_rd.delete();
  endtask

  task automatic model_op(input bit m, input int sl, input int th, input bit clr);
    exp_t e;
    int best, bi, dot;
    bit found;
    if (clr) for (int s = 0; s < N_TMPL; s++) ref_valid[s] = 0;
    if (m) begin
      if (sl < N_TMPL) begin
        for (int p = 0; p < N_PTS; p++) begin
          ref_lx[sl][p] = ref_vx[p];
          ref_ly[sl][p] = ref_vy[p];
          exp_wr_addr.push_back(sl * (1 << SLOT_LOG2) + p);
          exp_wr_data.push_back(((ref_vx[p] & 255) << 8) | (ref_vy[p] & 255));
        end
        ref_valid[sl] = 1;
      end
    end else begin
      found = 0; best = 0; bi = 0;
      for (int s = 0; s < N_TMPL; s++) begin
        if (ref_valid[s]) begin
          dot = 0;
          for (int p = 0; p < N_PTS; p++) begin
            exp_rd.push_back(s * (1 << SLOT_LOG2) + p);
            dot += ref_vx[p] * ref_lx[s][p] + ref_vy[p] * ref_ly[s][p];
          end
          if (!found || dot > best) begin best = dot; bi = s; found = 1; end
        end
      end
      last_idx   = found ? bi : 0;
      last_score = found ? best : 0;
      last_rej   = !found || (best < th);
    end
    e.idx = last_idx; e.score = last_score; e.rej = last_rej;
    for (int s = 0; s < N_TMPL; s++) e.tv[s] = ref_valid[s];
    exp_q.push_back(e);
  endtask

  // SRAM model: random grant delay, read data two cycles after grant, spurious gnt/rvalid.
  logic [15:0] mem [int];
  bit gnt_real = 0, outstanding = 0;
  int rd_cnt = 0, gdelay = 0, n_txn = 0;
  logic [ADDR_W-1:0] lat_addr;
  logic lat_we;
  logic [15:0] lat_wd;

  initial begin
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_rvalid = 0;
      mem_rdata  = 16'($urandom);
      if (rst) begin
        mem_gnt = 0; gnt_real = 0; rd_cnt = 0; outstanding = 0; gdelay = 0;
        continue;
      end
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          mem_rvalid  = 1;
          mem_rdata   = mem.exists(int'(lat_addr)) ? mem[int'(lat_addr)] : 16'h0;
          outstanding = 0;
        end
      end
      if (mem_gnt) begin
        mem_gnt = 0;
        if (gnt_real) begin
          n_txn++;
          if (lat_we) begin
            mem[int'(lat_addr)] = lat_wd;
            outstanding = 0;
            if (exp_wr_addr.size() == 0) chk("unexpected_write", 1, 0);
            else begin
              chk("wr_addr", lat_addr, exp_wr_addr.pop_front());
              chk("wr_data", lat_wd, exp_wr_data.pop_front());
            end
          end else begin
            rd_cnt = 1;
            if (exp_rd.size() == 0) chk("unexpected_read", 1, 0);
            else chk("rd_addr", lat_addr, exp_rd.pop_front());
          end
        end
      end else if (mem_req && !outstanding) begin
        if (gdelay > 0) gdelay--;
        else begin
          mem_gnt = 1; gnt_real = 1; outstanding = 1;
          lat_addr = mem_addr; lat_we = mem_we; lat_wd = mem_wdata;
          gdelay = $urandom_range(0, 2);
        end
      end else if (!mem_req && !outstanding && $urandom_range(0, 15) == 0) begin
        mem_gnt = 1; gnt_real = 0;
      end
      if (!outstanding && !mem_rvalid && $urandom_range(0, 15) == 0) mem_rvalid = 1;
    end
  end

  // Monitor: tmpl_valid checked in the DONE cycle, match outputs in the cycle after.
  bit pend = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) pend = 0;
      else if (pend) begin
        chk("match_idx", match_idx, cur.idx);
        chk("match_score", longint'($signed(match_score)), cur.score);
        chk("reject", reject, cur.rej);
        chk("busy_after_done", busy, 0);
        chk("done_pulse", done, 0);
        pend = 0;
      end else if (done) begin
        if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          cur = exp_q.pop_front();
          chk("tmpl_valid", tmpl_valid, cur.tv);
          chk("busy_in_done", busy, 1);
          pend = 1;
        end
      end
    end
  end

  task automatic write_pt(input int idx, input int x, input int y);
    @(negedge clk);
    vec_valid = 1; vec_idx = PIDX_W'(idx); vec_x = 8'(x); vec_y = 8'(y);
    ref_vx[idx] = x; ref_vy[idx] = y;
    @(negedge clk);
    vec_valid = 0;
  endtask

  task automatic load_all(input int x, input int y);
    for (int p = 0; p < N_PTS; p++) write_pt(p, x, y);
  endtask

  task automatic do_op(input bit m, input int sl, input int th, input bit clr,
                       input bit sv_en, input int sv_idx, input int sv_x, input int sv_y,
                       input bit junk, output int lat);
    bit seen;
    @(negedge clk);
    start = 1; mode = m; slot = TIDX_W'(sl); clear = clr; thr = SCORE_W'(th);
    if (sv_en) begin
      vec_valid = 1; vec_idx = PIDX_W'(sv_idx); vec_x = 8'(sv_x); vec_y = 8'(sv_y);
      ref_vx[sv_idx] = sv_x; ref_vy[sv_idx] = sv_y;
    end
    model_op(m, sl, th, clr);
    lat = 0; seen = 0;
    repeat (1000) begin
      @(negedge clk);
      lat++;
      start = 0; clear = 0; vec_valid = 0;
      if (done) begin seen = 1; break; end
      if (junk && busy && $urandom_range(0, 2) == 0) begin
        vec_valid = 1; vec_idx = PIDX_W'($urandom); vec_x = 8'($urandom); vec_y = 8'($urandom);
        clear = 1'($urandom); start = 1'($urandom); mode = 1'($urandom); slot = TIDX_W'($urandom);
      end
    end
    chk("op_done", seen, 1);
    $display("op mode=%0d slot=%0d thr=%0d clear=%0d cycles=%0d", m, sl, th, clr, lat);
    @(negedge clk);
  endtask

  int lat, txn0;

  initial begin
    ref_reset();
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_tmpl", tmpl_valid, 0);
    chk("rst_idx", match_idx, 0);
    chk("rst_score", match_score, 0);
    chk("rst_reject", reject, 0);
    rst = 0;

    // Enroll (1,0) into slot 2
    load_all(1, 0);
    do_op(1, 2, 0, 0, 0, 0, 0, 0, 0, lat);
    // Best of slots 0:(2,0) 1:(3,0) 2:(1,0) against (1,0)
    load_all(2, 0); do_op(1, 0, 0, 0, 0, 0, 0, 0, 0, lat);
    load_all(3, 0); do_op(1, 1, 0, 0, 0, 0, 0, 0, 0, lat);
    load_all(1, 0); do_op(0, 0, 0, 0, 0, 0, 0, 0, 0, lat);
    // Tie between slots 0 and 3, then threshold just above
    load_all(2, 0); do_op(1, 0, 0, 1, 0, 0, 0, 0, 0, lat);
    do_op(1, 3, 0, 0, 0, 0, 0, 0, 0, lat);
    load_all(1, 0);
    do_op(0, 0, 0, 0, 0, 0, 0, 0, 0, lat);
    do_op(0, 0, 9, 0, 0, 0, 0, 0, 0, lat);
    // Clear with start: empty walk, no memory traffic
    txn0 = n_txn;
    do_op(0, 0, 0, 1, 0, 0, 0, 0, 0, lat);
    chk("empty_scan_latency", lat, 5);
    chk("empty_scan_txns", n_txn - txn0, 0);
    // Negative coordinates
    load_all(4, -1); do_op(1, 1, 0, 0, 0, 0, 0, 0, 0, lat);
    load_all(-2, 3); do_op(0, 0, -100, 0, 0, 0, 0, 0, 0, lat);

    // Reset during WAIT of slot 1
    load_all(7, 2); do_op(1, 0, 0, 0, 0, 0, 0, 0, 0, lat);
    @(negedge clk);
    start = 1; mode = 0; thr = '0;
    model_op(0, 0, 0, 0);
    @(negedge clk);
    start = 0;
    begin
      bit hit = 0;
      for (int i = 0; i < 500 && !hit; i++) begin
        if (mem_req && mem_addr == ADDR_W'(1025)) hit = 1; else @(negedge clk);
      end
      for (int i = 0; i < 500 && hit && mem_req; i++) @(negedge clk);
      chk("reached_wait_slot1", hit, 1);
    end
    @(negedge clk);
    rst = 1;
    #1;
    chk("abort_req", mem_req, 0);
    chk("abort_busy", busy, 0);
    chk("abort_tmpl", tmpl_valid, 0);
    chk("abort_score", match_score, 0);
    ref_reset();
    repeat (2) @(negedge clk);
    rst = 0;
    do_op(0, 0, 0, 0, 0, 0, 0, 0, 0, lat);
    load_all(5, -7); do_op(1, 3, 0, 0, 0, 0, 0, 0, 0, lat);
    load_all(1, 1); do_op(0, 0, -8, 0, 0, 0, 0, 0, 0, lat);

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      int np = $urandom_range(0, N_PTS);
      for (int k = 0; k < np; k++)
        write_pt($urandom_range(0, N_PTS-1), int'($urandom_range(0, 255)) - 128,
                 int'($urandom_range(0, 255)) - 128);
      do_op(1'($urandom_range(0, 1)), $urandom_range(0, N_TMPL-1),
            int'($urandom_range(0, 80000)) - 40000, $urandom_range(0, 9) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, N_PTS-1),
            int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128, 1, lat);
    end
    repeat (3) @(negedge clk);
    chk("exp_queue_drained", exp_q.size(), 0);
    chk("exp_rd_drained", exp_rd.size(), 0);
    chk("exp_wr_drained", exp_wr_addr.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
